lane_delay_fifo: RTL and testbench



---
 rtl/lane_delay_fifo.sv | 110 +++++++++++
 tb/tb_lane_delay_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lane_delay_fifo.sv
// Per-lane programmable delay buffer: aligns a PCS lane to its peers by a
// counter-derived delay. Optional idle fill when not reading: LANE_FIFO_IDLE_FILL_EN.
module lane_delay_fifo #(
    parameter int NB_DATA        = 66,
    parameter int MAX_SKEW       = 16,
    parameter int NB_DELAY_COUNT = $clog2(MAX_SKEW) + 1
`ifdef LANE_FIFO_IDLE_FILL_EN
    ,
    parameter logic [NB_DATA-1:0] IDLE_BLOCK = 66'h1_E000_0000_0000_0000
`endif
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_valid,
    input  logic                      i_resync,
    input  logic                      i_enable_counter,
    input  logic                      i_stop_counter,
    input  logic                      i_set_delay,
    input  logic                      i_write_enb,
    input  logic                      i_read_enb,
    input  logic [NB_DELAY_COUNT-1:0] i_common_count,
    input  logic [NB_DATA-1:0]        i_data,
    output logic [NB_DATA-1:0]        o_data,
    output logic                      o_valid,
    output logic [NB_DELAY_COUNT-1:0] o_delay,
    output logic                      o_delay_err
);

    localparam int NB_ADDR = $clog2(MAX_SKEW);
    localparam logic [NB_DELAY_COUNT:0]   SKEW_LIMIT = (NB_DELAY_COUNT+1)'(MAX_SKEW);
    localparam logic [NB_DELAY_COUNT-1:0] MAX_DELAY  = NB_DELAY_COUNT'(MAX_SKEW - 1);
`ifdef LANE_FIFO_IDLE_FILL_EN
    localparam logic [NB_DATA-1:0] DATA_RESET = IDLE_BLOCK;
`else
    localparam logic [NB_DATA-1:0] DATA_RESET = '0;
`endif

    logic [NB_DATA-1:0]        r_mem [MAX_SKEW];
    logic [NB_DELAY_COUNT-1:0] r_lane_count;
    logic                      r_stopped;
    logic [NB_ADDR-1:0]        r_wr_ptr;
    logic [NB_DELAY_COUNT-1:0] r_delay;
    logic [NB_DATA-1:0]        r_data;
    logic                      r_valid;
    logic                      r_delay_err;

    logic [NB_DELAY_COUNT:0]   w_diff;
    logic                      w_range_err;
    logic [NB_ADDR-1:0]        w_rd_addr;
    logic                      w_count;

    // One extra bit of width exposes a negative difference as its MSB.
    assign w_diff      = {1'b0, i_common_count} - {1'b0, r_lane_count};
    assign w_range_err = w_diff[NB_DELAY_COUNT] || (w_diff >= SKEW_LIMIT);
    assign w_rd_addr   = r_wr_ptr - r_delay[NB_ADDR-1:0];
    assign w_count     = i_enable_counter && !i_stop_counter && !r_stopped
                         && (r_lane_count != '1);

    always_ff @(posedge i_clock) begin
        if (i_reset || i_resync) begin
            r_lane_count <= '0;
            r_stopped    <= 1'b0;
            r_wr_ptr     <= '0;
            r_delay      <= '0;
            r_data       <= DATA_RESET;
            r_valid      <= 1'b0;
            r_delay_err  <= 1'b0;
        end else if (i_valid) begin
            if (w_count)
                r_lane_count <= r_lane_count + 1'b1;
            if (i_stop_counter)
                r_stopped <= 1'b1;

            if (i_set_delay) begin
                if (w_range_err) begin
                    r_delay     <= MAX_DELAY;
                    r_delay_err <= 1'b1;
                end else begin
                    r_delay <= w_diff[NB_DELAY_COUNT-1:0];
                end
            end

            if (i_write_enb)
                r_wr_ptr <= r_wr_ptr + 1'b1;

            if (i_read_enb) begin
                r_data  <= (r_delay == '0) ? i_data : r_mem[w_rd_addr];
                r_valid <= 1'b1;
            end else begin
`ifdef LANE_FIFO_IDLE_FILL_EN
                r_data  <= IDLE_BLOCK;
`endif
                r_valid <= 1'b0;
            end
        end
    end

    // NOTE: the storage array has no reset so it maps onto plain RAM/register
    // files; stale entries are never observed once the delay is primed.
    always_ff @(posedge i_clock) begin
        if (i_valid && i_write_enb && !(i_reset || i_resync))
            r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_delay     = r_delay;
    assign o_delay_err = r_delay_err;

endmodule

// File: tb/tb_lane_delay_fifo.sv
// Self-checking bench for lane_delay_fifo: table-driven delay calculation plus
// hand-written stream, bypass, stall, sticky-error and resync sequences.
module tb_lane_delay_fifo;

    localparam int NB_DATA = 66;
    localparam int NB_DC   = 5;
`ifdef LANE_FIFO_IDLE_FILL_EN
    localparam logic [NB_DATA-1:0] IDLE     = 66'h1_E000_0000_0000_0000;
    localparam logic [NB_DATA-1:0] DATA_RST = IDLE;
`else
    localparam logic [NB_DATA-1:0] DATA_RST = '0;
`endif

    logic               i_clock = 1'b0;
    logic               i_reset, i_valid, i_resync, i_enable_counter, i_stop_counter;
    logic               i_set_delay, i_write_enb, i_read_enb;
    logic [NB_DC-1:0]   i_common_count;
    logic [NB_DATA-1:0] i_data;
    logic [NB_DATA-1:0] o_data;
    logic               o_valid;
    logic [NB_DC-1:0]   o_delay;
    logic               o_delay_err;

    int n_tests = 0;
    int n_fail  = 0;

    lane_delay_fifo dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_resync(i_resync),
        .i_enable_counter(i_enable_counter), .i_stop_counter(i_stop_counter),
        .i_set_delay(i_set_delay), .i_write_enb(i_write_enb), .i_read_enb(i_read_enb),
        .i_common_count(i_common_count), .i_data(i_data), .o_data(o_data),
        .o_valid(o_valid), .o_delay(o_delay), .o_delay_err(o_delay_err)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        int lane;
        int common;
        int exp_delay;
        bit exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [NB_DATA-1:0] act,
                         input logic [NB_DATA-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [NB_DATA-1:0] blk(input int n);
        return {2'b10, 64'hC0DE_0000_0000_0000} ^ NB_DATA'(n);
    endfunction

    // Inputs are driven 1 time unit after each rising edge; outputs sampled there too.
    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic resync_lane();
        i_resync = 1'b1;
        tick();
        i_resync = 1'b0;
    endtask

    task automatic count_lane(input int n);
        i_valid          = 1'b1;
        i_enable_counter = 1'b1;
        repeat (n) tick();
        i_stop_counter = 1'b1;
        tick();
        i_stop_counter   = 1'b0;
        i_enable_counter = 1'b0;
        i_valid          = 1'b0;
    endtask

    task automatic set_delay(input int common);
        i_valid        = 1'b1;
        i_set_delay    = 1'b1;
        i_common_count = NB_DC'(common);
        tick();
        i_set_delay = 1'b0;
        i_valid     = 1'b0;
    endtask

    initial begin
        vecs[0] = '{3, 9, 6, 1'b0};
        vecs[1] = '{9, 9, 0, 1'b0};
        vecs[2] = '{2, 20, 15, 1'b1};
        vecs[3] = '{5, 3, 15, 1'b1};
        vecs[4] = '{0, 15, 15, 1'b0};
        vecs[5] = '{0, 16, 15, 1'b1};
        vecs[6] = '{1, 0, 15, 1'b1};
        vecs[7] = '{7, 7, 0, 1'b0};
        vecs[8] = '{40, 31, 0, 1'b0};   // counter saturates at 31

        i_reset = 1'b1; i_valid = 1'b0; i_resync = 1'b0; i_enable_counter = 1'b0;
        i_stop_counter = 1'b0; i_set_delay = 1'b0; i_write_enb = 1'b0;
        i_read_enb = 1'b0; i_common_count = '0; i_data = '0;
        tick(); tick();
        check("reset_valid", NB_DATA'(o_valid), 0);
        check("reset_delay", NB_DATA'(o_delay), 0);
        check("reset_err", NB_DATA'(o_delay_err), 0);
        check("reset_data", o_data, DATA_RST);
        i_reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            resync_lane();
            check($sformatf("vec%0d_clr_err", i), NB_DATA'(o_delay_err), 0);
            count_lane(vecs[i].lane);
            set_delay(vecs[i].common);
            check($sformatf("vec%0d_delay", i), NB_DATA'(o_delay), NB_DATA'(vecs[i].exp_delay));
            check($sformatf("vec%0d_err", i), NB_DATA'(o_delay_err), NB_DATA'(vecs[i].exp_err));
        end

        // Counter freeze: stop wins over enable, valid-low cycles do not count.
        resync_lane();
        i_valid = 1'b1; i_enable_counter = 1'b1;
        repeat (7) tick();
        i_valid = 1'b0;
        tick();
        i_valid = 1'b1; i_stop_counter = 1'b1;
        tick();
        i_stop_counter = 1'b0;
        repeat (3) tick();
        i_enable_counter = 1'b0; i_valid = 1'b0;
        set_delay(7);
        check("freeze_delay0", NB_DATA'(o_delay), 0);
        set_delay(10);
        check("freeze_delay3", NB_DATA'(o_delay), 3);

        // Sticky error survives a later in-range re-latch.
        resync_lane();
        count_lane(2);
        set_delay(20);
        check("sticky_delay15", NB_DATA'(o_delay), 15);
        set_delay(5);
        check("sticky_relatch", NB_DATA'(o_delay), 3);
        check("sticky_err", NB_DATA'(o_delay_err), 1);

        // Bypass at delay 0.
        resync_lane();
        count_lane(9);
        set_delay(9);
        check("bypass_delay", NB_DATA'(o_delay), 0);
        i_valid = 1'b1; i_write_enb = 1'b1; i_read_enb = 1'b1; i_data = NB_DATA'(12'hABC);
        tick();
        check("bypass_data", o_data, NB_DATA'(12'hABC));
        check("bypass_valid", NB_DATA'(o_valid), 1);
        i_valid = 1'b0; i_write_enb = 1'b0; i_read_enb = 1'b0;

        // Continuous stream at delay 6, across several pointer wraps.
        resync_lane();
        count_lane(3);
        set_delay(9);
        check("stream_delay", NB_DATA'(o_delay), 6);
        i_valid = 1'b1; i_write_enb = 1'b1; i_read_enb = 1'b1;
        for (int n = 0; n < 40; n++) begin
            i_data = blk(n);
            tick();
            if (n >= 6) begin
                check($sformatf("stream_data%0d", n), o_data, blk(n - 6));
                check($sformatf("stream_valid%0d", n), NB_DATA'(o_valid), 1);
            end
        end
        i_write_enb = 1'b0; i_read_enb = 1'b0; i_data = blk(99);
        tick();
        check("noread_valid", NB_DATA'(o_valid), 0);
`ifdef LANE_FIFO_IDLE_FILL_EN
        check("noread_idle", o_data, IDLE);
`else
        check("noread_hold", o_data, blk(33));
`endif
        i_write_enb = 1'b1; i_read_enb = 1'b1;
        i_resync = 1'b1;
        tick();
        i_resync = 1'b0; i_valid = 1'b0; i_write_enb = 1'b0; i_read_enb = 1'b0;
        check("resync_valid", NB_DATA'(o_valid), 0);
        check("resync_delay", NB_DATA'(o_delay), 0);
        check("resync_err", NB_DATA'(o_delay_err), 0);
        check("resync_data", o_data, DATA_RST);
        set_delay(5);
        check("resync_counter0", NB_DATA'(o_delay), 5);

        // Stall: i_valid toggles, delay 4; output advances only on valid cycles.
        resync_lane();
        set_delay(4);
        check("stall_delay", NB_DATA'(o_delay), 4);
        i_write_enb = 1'b1; i_read_enb = 1'b1;
        for (int n = 0; n < 20; n++) begin
            i_valid = 1'b1; i_data = blk(n);
            tick();
            if (n >= 4) check($sformatf("stall_data%0d", n), o_data, blk(n - 4));
            i_valid = 1'b0; i_data = blk(200 + n);
            tick();
            if (n >= 4) begin
                check($sformatf("stall_hold%0d", n), o_data, blk(n - 4));
                check($sformatf("stall_hvalid%0d", n), NB_DATA'(o_valid), 1);
            end
        end
        i_write_enb = 1'b0; i_read_enb = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
